ad80305_spi_arbiter: RTL and testbench
======================================

# ad80305_spi_arbiter

Command scheduler in front of the shared AD80305 SPI driver. It accepts single-register read/write commands from two requesters: the power-up configuration sequencer (port 0) and the monitor/host register path (port 1). It arbitrates between them round-robin and sequences the driver's edge-triggered enables and its result/busy flag. It returns read data or a timeout error to the requester that issued the command.

## Interface
Parameters:
- START_TO, 32: max cycles in ISSUE waiting for driver busy (`i_spi_rw_result`==0).
- BUSY_TO, 8191: max cycles in BUSY waiting for driver idle (`i_spi_rw_result`==1).
- GAP, 4: idle cycles forced between transactions; must be ≥3.

Ports:
- `i_fpga_clk_125p`  in  1  clock.
- `i_fpga_rst_125p`  in  1  reset: asynchronous, active-low.
- `i_req0_valid` / `o_req0_ready`  in/out  1  port-0 command handshake.
- `i_req0_wr`  in  1  1=write, 0=read.
- `i_req0_chip`  in  2  chip select code: 0 or 1.
- `i_req0_addr`  in  10  register address.
- `i_req0_data`  in  8  write data.
- `i_req1_*` / `o_req1_ready`: same set for port 1.
- `o_rsp0_valid`, `o_rsp1_valid`  out  1  one-cycle completion pulse per port.
- `o_rsp_rdata`  out  8  read data; 0x00 for writes and on error.
- `o_rsp_err`  out  1  timeout flag, valid with the response pulse.
- `o_spi_rd_en`, `o_spi_wr_en`  out  1  level enables to the driver; the driver detects their rising edge.
- `o_spi_mod_sel`  out  3  constant 3'b000.
- `o_spi_chip_sel`  out  2  chip code of the current command.
- `o_spi_addr`  out  10  address of the current command.
- `o_spi_data`  out  8  write data of the current command.
- `i_spi_rw_result`  in  8  driver status: 1=idle/ok, 0=busy.
- `i_spi_rw_data`  in  8  driver read data.
- `o_busy`  out  1  high in any state except IDLE.
- `o_err_cnt`  out  8  saturating timeout count.

## Operation
State machine: IDLE → ISSUE → BUSY → DONE → GAP → IDLE.

- **IDLE**
  - Grant = round-robin over `i_reqN_valid`. The last-grant pointer resets to 1, so port 0 wins the first tie.
  - `o_reqN_ready` = (state==IDLE) & grantN. This is combinational; at most one port is ready at a time.
  - On valid&ready: latch wr/chip/addr/data and the port ID into command registers, update the pointer, go to ISSUE.
- **ISSUE**
  - Assert `o_spi_wr_en` (wr) or `o_spi_rd_en` (read) and start the timer.
  - If `i_spi_rw_result`==0: deassert the enable, clear the timer, go to BUSY.
  - If the timer reaches START_TO: set error, go to DONE.
- **BUSY**
  - Enables low.
  - If `i_spi_rw_result`==1: go to DONE.
  - If the timer reaches BUSY_TO: set error, go to DONE.
- **DONE** (one cycle)
  - Pulse `o_rspN_valid` for the latched port.
  - `o_rsp_rdata` = `i_spi_rw_data` for an error-free read, else 0x00.
  - On error, `o_err_cnt`++ (saturates at 255).
- **GAP**
  - Count GAP cycles with enables low, so the driver's 2-flop edge detector sees a low level before the next transaction.
- `o_spi_chip_sel`, `o_spi_addr`, `o_spi_data` come straight from the command registers. They must not change from ISSUE through DONE, because the driver samples them live throughout the frame.
- An input chip code of 2 or 3 is passed through unchanged. The driver asserts no CS and still completes, so this is not an error.
- A request arriving while not in IDLE waits; requesters hold valid and fields until ready.

## Timing
- Reset values:
  - ready0/1=0, rsp0/1_valid=0, `o_rsp_rdata`=0, `o_rsp_err`=0.
  - `o_spi_rd_en`=`o_spi_wr_en`=0, `o_spi_mod_sel`=0.
  - `o_spi_chip_sel`=2'b11, `o_spi_addr`=0, `o_spi_data`=0.
  - `o_busy`=0, `o_err_cnt`=0, state=IDLE.
- Accept at cycle T → enable high at T+1.
- With the production driver, `i_spi_rw_result` falls about 5 cycles after the enable rises. The frame then lasts about 35×125 cycles, after which the response pulses.
- Ready and response outputs are registered except ready, which is combinational.
- Both valid together in IDLE → only the granted port is ready. The other port is granted on the next IDLE.
- Reset mid-transaction: all outputs return to reset values immediately and the command is dropped with no response. Requesters must reissue.
- Timer width is ⌈log2(BUSY_TO+1)⌉. The error counter never wraps.

## Structure
- Package `ad80305_spi_pkg`:
  - state encoding enum;
  - command struct {wr, chip[1:0], addr[9:0], data[7:0]};
  - constants MOD_SINGLE=3'b000, RESULT_OK=8'd1, RESULT_BUSY=8'd0.
- Sub-module `rr_arb2`: 2-way round-robin grant with pointer update on accept.
- The state machine, timer and output registers stay in the top module.

## Test plan
- Port-0 write chip 0, addr 0x0A5, data 0x3C, with the real driver → MOSI bits 1,000,00,0010100101,00111100. `o_rsp0_valid` pulses with err=0 and rdata=0x00.
- Port-1 read chip 1, addr 0x005, bench drives MISO 0xA7 → `o_rsp1_valid` pulses with rdata=0xA7, and cs1 is low through the frame.
- Both ports valid continuously for 4 commands each → grants alternate 0,1,0,1…. Every pair of enable rising edges is separated by ≥GAP cycles low.
- Stub driver holds result=1 → after START_TO cycles the response carries err=1 and rdata=0x00, `o_err_cnt`=1, and enables are low.
- Stub driver holds result=0 → timeout at BUSY_TO. After 256 repeats, `o_err_cnt` stays at 255.
- Reset asserted during BUSY → all outputs at reset values, no response. The next command completes normally.

Source files
------------

// File: rtl/ad80305_spi_pkg.sv
// Purpose: shared types and constants for the AD80305 SPI command arbiter.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, the latched command record, driver mode and
// status codes, and a saturating 8-bit increment used by the error counter.
package ad80305_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_BUSY  = 3'd2,
        ST_DONE  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // One single-register access as handed to the driver.
    typedef struct packed {
        logic       wr;
        logic [1:0] chip;
        logic [9:0] addr;
        logic [7:0] data;
    } cmd_t;

    localparam logic [2:0] MOD_SINGLE  = 3'b000;
    localparam logic [7:0] RESULT_OK   = 8'd1;
    localparam logic [7:0] RESULT_BUSY = 8'd0;

    // Idle command register contents: chip code 3 selects no device.
    localparam cmd_t CMD_RESET = '{wr: 1'b0, chip: 2'b11, addr: 10'd0, data: 8'd0};

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ad80305_spi_arbiter_rr_arb2.sv
// Purpose: two-way round-robin grant for the SPI command arbiter.
// Latency: grant is combinational from req; pointer moves one cycle after accept.
// Backpressure: none of its own; the caller gates grants into ready.
//
// Ports:
//   i_fpga_clk_125p / i_fpga_rst_125p : clock, async active-low reset
//   req[1:0]  : requester valids          accept : a granted request was taken
//   gnt[1:0]  : one-hot (or zero) grant
module rr_arb2
    import ad80305_spi_pkg::*;
(
    input  logic       i_fpga_clk_125p,
    input  logic       i_fpga_rst_125p,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    // Port id of the most recent accepted grant. Resetting to 1 lets port 0
    // win the very first tie.
    logic last_q;

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || last_q)) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end

    always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
        if (!i_fpga_rst_125p) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/ad80305_spi_arbiter.sv
// Purpose: schedules single-register commands from two requesters onto the shared AD80305 SPI driver.
// Latency: enable rises 1 cycle after accept; response pulses 1 cycle after driver idle or timeout.
// Backpressure: ready only in IDLE for the granted port; requesters hold valid and fields until ready.
//
// Ports:
//   i_fpga_clk_125p, i_fpga_rst_125p        : clock, async active-low reset
//   i_reqN_valid/o_reqN_ready, i_reqN_wr/chip/addr/data : command ports 0 (config seq) and 1 (host)
//   o_rsp0_valid, o_rsp1_valid, o_rsp_rdata, o_rsp_err   : one-cycle completion per port
//   o_spi_rd_en/wr_en/mod_sel/chip_sel/addr/data         : driver command (enables are edge-detected)
//   i_spi_rw_result, i_spi_rw_data                       : driver status (1 idle, 0 busy) and read data
//   o_busy, o_err_cnt                                    : activity flag, saturating timeout count
module ad80305_spi_arbiter
    import ad80305_spi_pkg::*;
#(
    parameter int START_TO = 32,
    parameter int BUSY_TO  = 8191,
    parameter int GAP      = 4      // must be >= 3 so the driver's 2-flop edge detector sees low
)(
    input  logic        i_fpga_clk_125p,
    input  logic        i_fpga_rst_125p,

    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic        i_req0_wr,
    input  logic [1:0]  i_req0_chip,
    input  logic [9:0]  i_req0_addr,
    input  logic [7:0]  i_req0_data,

    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic        i_req1_wr,
    input  logic [1:0]  i_req1_chip,
    input  logic [9:0]  i_req1_addr,
    input  logic [7:0]  i_req1_data,

    output logic        o_rsp0_valid,
    output logic        o_rsp1_valid,
    output logic [7:0]  o_rsp_rdata,
    output logic        o_rsp_err,

    output logic        o_spi_rd_en,
    output logic        o_spi_wr_en,
    output logic [2:0]  o_spi_mod_sel,
    output logic [1:0]  o_spi_chip_sel,
    output logic [9:0]  o_spi_addr,
    output logic [7:0]  o_spi_data,
    input  logic [7:0]  i_spi_rw_result,
    input  logic [7:0]  i_spi_rw_data,

    output logic        o_busy,
    output logic [7:0]  o_err_cnt
);

    // One shared timer serves ISSUE, BUSY and GAP; BUSY_TO is the largest limit.
    localparam int TW = $clog2(BUSY_TO + 1);
    localparam logic [TW-1:0] START_LAST = TW'(START_TO - 1);
    localparam logic [TW-1:0] BUSY_LAST  = TW'(BUSY_TO - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    state_t        state_q, nxt_state;
    logic [TW-1:0] timer_q, nxt_timer;
    cmd_t          cmd_q, nxt_cmd;
    logic          port_q, nxt_port;
    logic          rd_en_q, nxt_rd_en;
    logic          wr_en_q, nxt_wr_en;
    logic          rsp0_q, nxt_rsp0;
    logic          rsp1_q, nxt_rsp1;
    logic [7:0]    rdata_q, nxt_rdata;
    logic          err_q, nxt_err;
    logic [7:0]    err_cnt_q, nxt_err_cnt;
    logic          finish, fin_err;

    cmd_t          req0_cmd, req1_cmd, sel_cmd;
    logic [1:0]    arb_gnt;
    logic          idle;
    logic          accept;

    assign req0_cmd = '{wr: i_req0_wr, chip: i_req0_chip, addr: i_req0_addr, data: i_req0_data};
    assign req1_cmd = '{wr: i_req1_wr, chip: i_req1_chip, addr: i_req1_addr, data: i_req1_data};

    assign idle         = (state_q == ST_IDLE);
    assign o_req0_ready = idle & arb_gnt[0];
    assign o_req1_ready = idle & arb_gnt[1];
    assign accept       = o_req0_ready | o_req1_ready;
    assign sel_cmd      = arb_gnt[1] ? req1_cmd : req0_cmd;

    rr_arb2 u_arb (
        .i_fpga_clk_125p (i_fpga_clk_125p),
        .i_fpga_rst_125p (i_fpga_rst_125p),
        .req             ({i_req1_valid, i_req0_valid}),
        .accept          (accept),
        .gnt             (arb_gnt)
    );

    always_comb begin
        nxt_state   = state_q;
        nxt_timer   = timer_q;
        nxt_cmd     = cmd_q;
        nxt_port    = port_q;
        nxt_rd_en   = 1'b0;
        nxt_wr_en   = 1'b0;
        nxt_rsp0    = 1'b0;
        nxt_rsp1    = 1'b0;
        nxt_rdata   = 8'h00;
        nxt_err     = 1'b0;
        nxt_err_cnt = err_cnt_q;
        finish      = 1'b0;
        fin_err     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    nxt_cmd   = sel_cmd;
                    nxt_port  = arb_gnt[1];
                    nxt_wr_en = sel_cmd.wr;
                    nxt_rd_en = !sel_cmd.wr;
                    nxt_timer = '0;
                    nxt_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (i_spi_rw_result == RESULT_BUSY) begin
                    // Driver has taken the edge; drop the enable so the next
                    // command can produce a fresh rising edge.
                    nxt_timer = '0;
                    nxt_state = ST_BUSY;
                end else if (timer_q == START_LAST) begin
                    finish  = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    nxt_timer = timer_q + TIMER_ONE;
                    nxt_wr_en = cmd_q.wr;
                    nxt_rd_en = !cmd_q.wr;
                end
            end
            ST_BUSY: begin
                if (i_spi_rw_result == RESULT_OK) begin
                    finish = 1'b1;
                end else if (timer_q == BUSY_LAST) begin
                    finish  = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    nxt_timer = timer_q + TIMER_ONE;
                end
            end
            ST_DONE: begin
                nxt_timer = '0;
                nxt_state = ST_GAP;
            end
            ST_GAP: begin
                if (timer_q == GAP_LAST) begin
                    nxt_state = ST_IDLE;
                end else begin
                    nxt_timer = timer_q + TIMER_ONE;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
            end
        endcase

        // Response fields are registered on entry to DONE so they are valid
        // for exactly the DONE cycle.
        if (finish) begin
            nxt_state = ST_DONE;
            nxt_rsp0  = !port_q;
            nxt_rsp1  = port_q;
            nxt_err   = fin_err;
            nxt_rdata = (!fin_err && !cmd_q.wr) ? i_spi_rw_data : 8'h00;
            if (fin_err) begin
                nxt_err_cnt = sat_inc8(err_cnt_q);
            end
        end
    end

    always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
        if (!i_fpga_rst_125p) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            cmd_q     <= CMD_RESET;
            port_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            rsp0_q    <= 1'b0;
            rsp1_q    <= 1'b0;
            rdata_q   <= 8'h00;
            err_q     <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            state_q   <= nxt_state;
            timer_q   <= nxt_timer;
            cmd_q     <= nxt_cmd;
            port_q    <= nxt_port;
            rd_en_q   <= nxt_rd_en;
            wr_en_q   <= nxt_wr_en;
            rsp0_q    <= nxt_rsp0;
            rsp1_q    <= nxt_rsp1;
            rdata_q   <= nxt_rdata;
            err_q     <= nxt_err;
            err_cnt_q <= nxt_err_cnt;
        end
    end

    // Command fields come straight from cmd_q, which only loads in IDLE, so
    // they hold steady for the whole driver frame.
    assign o_spi_chip_sel = cmd_q.chip;
    assign o_spi_addr     = cmd_q.addr;
    assign o_spi_data     = cmd_q.data;
    assign o_spi_mod_sel  = MOD_SINGLE;
    assign o_spi_rd_en    = rd_en_q;
    assign o_spi_wr_en    = wr_en_q;
    assign o_rsp0_valid   = rsp0_q;
    assign o_rsp1_valid   = rsp1_q;
    assign o_rsp_rdata    = rdata_q;
    assign o_rsp_err      = err_q;
    assign o_busy         = !idle;
    assign o_err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_ad80305_spi_arbiter.sv
// Purpose: directed self-checking bench for ad80305_spi_arbiter with a small driver model.
// Latency: n/a.
// Backpressure: requesters hold valid and fields until ready, as the real ones do.
`timescale 1ns/1ps
module tb_ad80305_spi_arbiter;

    localparam int START_TO  = 16;
    localparam int BUSY_TO   = 64;
    localparam int GAP       = 4;
    localparam int FRAME_LEN = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 0, req0_wr = 0;
    logic [1:0] req0_chip = 0;
    logic [9:0] req0_addr = 0;
    logic [7:0] req0_data = 0;
    logic       req1_valid = 0, req1_wr = 0;
    logic [1:0] req1_chip = 0;
    logic [9:0] req1_addr = 0;
    logic [7:0] req1_data = 0;
    logic [7:0] rw_result = 8'd1;
    logic [7:0] rw_data = 8'd0;

    logic       o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid, o_rsp_err;
    logic [7:0] o_rsp_rdata, o_spi_data, o_err_cnt;
    logic       o_spi_rd_en, o_spi_wr_en, o_busy;
    logic [2:0] o_spi_mod_sel;
    logic [1:0] o_spi_chip_sel;
    logic [9:0] o_spi_addr;

    ad80305_spi_arbiter #(.START_TO(START_TO), .BUSY_TO(BUSY_TO), .GAP(GAP)) dut (
        .i_fpga_clk_125p (clk),
        .i_fpga_rst_125p (rst_n),
        .i_req0_valid    (req0_valid),
        .o_req0_ready    (o_req0_ready),
        .i_req0_wr       (req0_wr),
        .i_req0_chip     (req0_chip),
        .i_req0_addr     (req0_addr),
        .i_req0_data     (req0_data),
        .i_req1_valid    (req1_valid),
        .o_req1_ready    (o_req1_ready),
        .i_req1_wr       (req1_wr),
        .i_req1_chip     (req1_chip),
        .i_req1_addr     (req1_addr),
        .i_req1_data     (req1_data),
        .o_rsp0_valid    (o_rsp0_valid),
        .o_rsp1_valid    (o_rsp1_valid),
        .o_rsp_rdata     (o_rsp_rdata),
        .o_rsp_err       (o_rsp_err),
        .o_spi_rd_en     (o_spi_rd_en),
        .o_spi_wr_en     (o_spi_wr_en),
        .o_spi_mod_sel   (o_spi_mod_sel),
        .o_spi_chip_sel  (o_spi_chip_sel),
        .o_spi_addr      (o_spi_addr),
        .o_spi_data      (o_spi_data),
        .i_spi_rw_result (rw_result),
        .i_spi_rw_data   (rw_data),
        .o_busy          (o_busy),
        .o_err_cnt       (o_err_cnt)
    );

    always #4 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- driver model ----------------
    // mode 0: edge-detect enable, go busy ~5 cycles later, stay busy FRAME_LEN, return miso
    // mode 1: stuck idle (result=1); mode 2: stuck busy (result=0)
    int          drv_mode = 0;
    logic [7:0]  miso = 8'h00;
    bit          drv_act = 0, en_prev = 0, en_now;
    int          drv_cnt = 0;
    logic [23:0] frm_word = '0;
    bit          stab_err = 0, cs1_all = 0;
    int          en_rise_cyc = 0;
    int          low_run = 0, min_low = 1000;
    bit          seen_rise = 0;

    initial forever begin
        @(negedge clk);
        en_now = o_spi_rd_en | o_spi_wr_en;
        if (en_now) begin
            if (!en_prev) begin
                if (seen_rise && low_run < min_low) min_low = low_run;
                seen_rise = 1;
            end
            low_run = 0;
        end else begin
            low_run++;
        end
        if (drv_mode == 1) begin
            drv_act = 0; rw_result = 8'd1; rw_data = 8'hFF;
        end else if (drv_mode == 2) begin
            drv_act = 0; rw_result = 8'd0; rw_data = 8'hFF;
        end else if (!drv_act) begin
            rw_result = 8'd1;
            if (en_now && !en_prev) begin
                drv_act     = 1;
                drv_cnt     = 0;
                en_rise_cyc = cyc;
                frm_word    = {o_spi_wr_en, o_spi_mod_sel, o_spi_chip_sel, o_spi_addr, o_spi_data};
                stab_err    = 0;
                cs1_all     = (o_spi_chip_sel == 2'd1);
            end
        end else begin
            drv_cnt++;
            if ({o_spi_mod_sel, o_spi_chip_sel, o_spi_addr, o_spi_data} != frm_word[22:0]) stab_err = 1;
            if (o_spi_chip_sel != 2'd1) cs1_all = 0;
            if (drv_cnt == 4) rw_result = 8'd0;
            if (drv_cnt == 4 + FRAME_LEN) begin
                rw_result = 8'd1;
                rw_data   = miso;
                drv_act   = 0;
            end
        end
        en_prev = en_now;
    end

    // ---------------- requester tasks ----------------
    int last_acc_cyc = 0;
    int grant_log[$];

    task automatic send(input int p, input logic wr, input logic [1:0] chip, input logic [9:0] addr,
                        input logic [7:0] data, output int t0, output bit ok);
        ok = 0;
        t0 = 0;
        if (p == 0) begin
            req0_wr = wr; req0_chip = chip; req0_addr = addr; req0_data = data; req0_valid = 1;
        end else begin
            req1_wr = wr; req1_chip = chip; req1_addr = addr; req1_data = data; req1_valid = 1;
        end
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if ((p == 0) ? o_req0_ready : o_req1_ready) ok = 1;
        end
        chk($sformatf("grant_p%0d", p), ok, 1);
        if (ok) begin
            t0 = cyc;
            last_acc_cyc = cyc;
            grant_log.push_back(p);
            @(posedge clk);
            #1;
        end
        if (p == 0) req0_valid = 0; else req1_valid = 0;
    endtask

    task automatic wait_rsp(input int p, input int t0, output int lat, output logic [7:0] rdata,
                            output logic err);
        bit got = 0;
        lat = -1; rdata = 8'hEE; err = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if ((p == 0) ? o_rsp0_valid : o_rsp1_valid) begin
                got = 1; lat = cyc - t0; rdata = o_rsp_rdata; err = o_rsp_err;
            end
        end
        chk($sformatf("rsp_p%0d", p), got, 1);
    endtask

    task automatic issue(input int p, input logic wr, input logic [1:0] chip, input logic [9:0] addr,
                         input logic [7:0] data, output int lat, output logic [7:0] rdata, output logic err);
        int t0; bit ok;
        send(p, wr, chip, addr, data, t0, ok);
        lat = -1; rdata = 8'hEE; err = 1'b1;
        if (ok) wait_rsp(p, t0, lat, rdata, err);
    endtask

    task automatic check_idle_outs(input string tag);
        chk({tag, "_rdy0"},  o_req0_ready, 0);
        chk({tag, "_rdy1"},  o_req1_ready, 0);
        chk({tag, "_rsp0"},  o_rsp0_valid, 0);
        chk({tag, "_rsp1"},  o_rsp1_valid, 0);
        chk({tag, "_rdata"}, o_rsp_rdata, 0);
        chk({tag, "_err"},   o_rsp_err, 0);
        chk({tag, "_en"},    {o_spi_rd_en, o_spi_wr_en}, 0);
        chk({tag, "_mod"},   o_spi_mod_sel, 0);
        chk({tag, "_chip"},  o_spi_chip_sel, 2'b11);
        chk({tag, "_addr"},  o_spi_addr, 0);
        chk({tag, "_data"},  o_spi_data, 0);
        chk({tag, "_busy"},  o_busy, 0);
        chk({tag, "_ecnt"},  o_err_cnt, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat; logic [7:0] rd; logic er;
        int t0; bit ok; bit rsp_seen;
        logic [7:0] gbits;

        repeat (3) @(negedge clk);
        check_idle_outs("reset");
        rst_n = 1;
        repeat (2) @(negedge clk);

        // Port-0 write, chip 0, addr 0x0A5, data 0x3C. Read-back data must be forced to 0.
        drv_mode = 0; miso = 8'h5A;
        issue(0, 1'b1, 2'd0, 10'h0A5, 8'h3C, lat, rd, er);
        chk("wr_frame", frm_word, 24'b1_000_00_0010100101_00111100);
        chk("wr_en_latency", en_rise_cyc - last_acc_cyc, 1);
        chk("wr_err", er, 0);
        chk("wr_rdata", rd, 8'h00);
        chk("wr_stable", stab_err, 0);

        // Port-1 read, chip 1, addr 0x005, MISO 0xA7.
        miso = 8'hA7;
        issue(1, 1'b0, 2'd1, 10'h005, 8'h00, lat, rd, er);
        chk("rd_frame", frm_word, 24'b0_000_01_0000000101_00000000);
        chk("rd_rdata", rd, 8'hA7);
        chk("rd_err", er, 0);
        chk("rd_cs1_held", cs1_all, 1);
        chk("rd_stable", stab_err, 0);

        // Both ports saturating the arbiter: grants must alternate, port 0 first.
        grant_log.delete(); min_low = 1000; seen_rise = 0; miso = 8'h3D;
        begin
            int ok0 = 0, ok1 = 0;
            fork
                begin
                    int l0; logic [7:0] r0; logic e0;
                    for (int k = 0; k < 4; k++) begin
                        issue(0, 1'b0, 2'd0, 10'h100 + 10'(k), 8'h00, l0, r0, e0);
                        if (r0 == 8'h3D && !e0) ok0++;
                    end
                end
                begin
                    int l1; logic [7:0] r1; logic e1;
                    for (int k = 0; k < 4; k++) begin
                        issue(1, 1'b0, 2'd1, 10'h200 + 10'(k), 8'h00, l1, r1, e1);
                        if (r1 == 8'h3D && !e1) ok1++;
                    end
                end
            join
            chk("alt_ok0", ok0, 4);
            chk("alt_ok1", ok1, 4);
        end
        gbits = 8'h00;
        for (int i = 0; i < grant_log.size() && i < 8; i++) gbits[i] = grant_log[i][0];
        chk("alt_count", grant_log.size(), 8);
        chk("alt_order", gbits, 8'hAA);
        chk("alt_gap", (min_low >= GAP), 1);

        // Driver never goes busy: start timeout.
        repeat (2) @(negedge clk);
        drv_mode = 1;
        issue(0, 1'b0, 2'd0, 10'h011, 8'h00, lat, rd, er);
        chk("sto_lat", lat, START_TO + 1);
        chk("sto_err", er, 1);
        chk("sto_rdata", rd, 8'h00);
        chk("sto_ecnt", o_err_cnt, 1);
        chk("sto_en_low", {o_spi_rd_en, o_spi_wr_en}, 0);

        // Driver never returns idle: busy timeout, then saturate the counter.
        drv_mode = 2;
        issue(1, 1'b0, 2'd1, 10'h022, 8'h00, lat, rd, er);
        chk("bto_lat", lat, BUSY_TO + 2);
        chk("bto_err", er, 1);
        chk("bto_rdata", rd, 8'h00);
        chk("bto_ecnt", o_err_cnt, 2);
        for (int k = 0; k < 256; k++) begin
            issue(k % 2, 1'b1, 2'd0, 10'h033, 8'h55, lat, rd, er);
            if (k == 251) chk("ecnt_254", o_err_cnt, 254);
            if (k == 252) chk("ecnt_255", o_err_cnt, 255);
        end
        chk("ecnt_sat", o_err_cnt, 255);

        // Reset while BUSY: everything back to reset values, no response.
        repeat (6) @(negedge clk);
        send(0, 1'b0, 2'd1, 10'h044, 8'h00, t0, ok);
        repeat (6) @(negedge clk);
        chk("midrst_busy_before", o_busy, 1);
        #1 rst_n = 0;
        #1;
        check_idle_outs("midrst");
        rsp_seen = 0;
        repeat (4) begin @(negedge clk); rsp_seen |= o_rsp0_valid | o_rsp1_valid; end
        rst_n = 1;
        drv_mode = 0; miso = 8'h96;
        repeat (8) begin @(negedge clk); rsp_seen |= o_rsp0_valid | o_rsp1_valid; end
        chk("midrst_no_rsp", rsp_seen, 0);
        issue(0, 1'b0, 2'd1, 10'h044, 8'h00, lat, rd, er);
        chk("post_rst_rdata", rd, 8'h96);
        chk("post_rst_err", er, 0);
        chk("post_rst_ecnt", o_err_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_mis);
        $fatal(1, "watchdog");
    end

endmodule
